// File: rtl/minas_pkg.sv
// Shared types and constants for the minesweeper play engine: grid geometry,
// game/FSM state encodings, the neighbour walk order and cell indexing.
package minas_pkg;

   localparam int N      = 8;
   localparam int CONT_W = 3;
   localparam int CELDAS = N * N;
   localparam int FILA_W = $clog2(N);
   localparam int IDX_W  = 2 * FILA_W;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      JUGANDO = 2'd1,
      PERDIDO = 2'd2,
      GANADO  = 2'd3
   } estado_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      POP    = 3'd2,
      VECINO = 3'd3,
      VERIF  = 3'd4,
      FIN    = 3'd5
   } fsm_t;

   // Neighbour offsets walked in the order NW, N, NE, W, E, SW, S, SE.
   localparam logic signed [1:0] DFILA [8] =
      '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
   localparam logic signed [1:0] DCOL  [8] =
      '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};

   // Linear cell index: row-major, fila*N + col (N is a power of two).
   function automatic logic [IDX_W-1:0] idx(input logic [FILA_W-1:0] fila,
                                            input logic [FILA_W-1:0] col);
      return {fila, col};
   endfunction

endpackage

// File: rtl/pila_celdas.sv
// LIFO of cell indices used by the flood fill. The top of stack is read
// combinationally so a pop can hand the cell to the engine in the same cycle.
module pila_celdas
   import minas_pkg::*;
#(
   parameter int DEPTH = CELDAS,
   parameter int W     = IDX_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         vacia_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  ptr_q, ptr_d;

   // Pointer update: clear wins, then push, then pop (never both at once).
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (push_i) begin
         ptr_d = ptr_q + 1'b1;
      end else if (pop_i && (ptr_q != '0)) begin
         ptr_d = ptr_q - 1'b1;
      end
   end

   // Stack pointer register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Storage; contents need no reset because the pointer defines validity.
   always_ff @(posedge clk_i) begin
      if (push_i && !clr_i) begin
         mem_q[ptr_q[AW-1:0]] <= din_i;
      end
   end

   assign dout_o  = mem_q[AW'(ptr_q - 1'b1)];
   assign vacia_o = (ptr_q == '0);

endmodule

// File: rtl/revelar_celdas.sv
// Minesweeper play engine: executes reveal / flag / new-game actions on the
// mine map, runs an iterative flood fill for zero-count cells through a LIFO,
// and tracks win/loss plus the reveal and flag masks for the display.
module revelar_celdas
   import minas_pkg::*;
#(
   parameter int N      = minas_pkg::N,
   parameter int CONT_W = minas_pkg::CONT_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     iniciar_i,
   input  logic                     btn_revelar_i,
   input  logic                     btn_bandera_i,
   input  logic [$clog2(N)-1:0]     cursor_fila_i,
   input  logic [$clog2(N)-1:0]     cursor_col_i,
   input  logic [N*N-1:0]           minas_i,
   input  logic [N*N*CONT_W-1:0]    conteos_i,
   output logic [N*N-1:0]           revelada_o,
   output logic [N*N-1:0]           bandera_o,
   output logic [1:0]               estado_o,
   output logic                     ocupado_o,
   output logic [$clog2(N*N):0]     celdas_reveladas_o
);

   localparam int C     = N * N;
   localparam int FW    = $clog2(N);
   localparam int IW    = 2 * FW;
   localparam int CNT_W = $clog2(C) + 1;

   fsm_t              fsm_q, fsm_d;
   estado_t           estado_q, estado_d;
   logic [C-1:0]      revelada_q, revelada_d;
   logic [C-1:0]      bandera_q, bandera_d;
   logic [CNT_W-1:0]  cuenta_q, cuenta_d;
   logic [IW-1:0]     cel_q, cel_d;
   logic [2:0]        k_q, k_d;

   logic              pila_push, pila_pop, pila_clr, pila_vacia;
   logic [IW-1:0]     pila_din, pila_dout;

   logic [C-1:0]      es_cero;
   logic [IW-1:0]     cursor_idx;
   logic [FW+1:0]     vec_fila, vec_col;
   logic              vec_en_rango;
   logic [IW-1:0]     vec_idx;

   // Per-cell "adjacency count is zero" flags.
   genvar gi;
   generate
      for (gi = 0; gi < C; gi++) begin : g_cero
         assign es_cero[gi] = (conteos_i[gi*CONT_W +: CONT_W] == '0);
      end
   endgenerate

   assign cursor_idx = idx(cursor_fila_i, cursor_col_i);

   // Current neighbour coordinates, two bits wider than a row so that a step
   // off either edge shows up in the top bits instead of wrapping.
   always_comb begin
      vec_fila = {2'b00, cel_q[IW-1:FW]} + {{FW{DFILA[k_q][1]}}, DFILA[k_q]};
      vec_col  = {2'b00, cel_q[FW-1:0]}  + {{FW{DCOL[k_q][1]}},  DCOL[k_q]};
      vec_en_rango = (vec_fila[FW+1:FW] == 2'b00) && (vec_col[FW+1:FW] == 2'b00);
      vec_idx  = {vec_fila[FW-1:0], vec_col[FW-1:0]};
   end

   pila_celdas #(
      .DEPTH (C),
      .W     (IW)
   ) u_pila (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (pila_clr),
      .push_i  (pila_push),
      .pop_i   (pila_pop),
      .din_i   (pila_din),
      .dout_o  (pila_dout),
      .vacia_o (pila_vacia)
   );

   // Next-state and datapath updates; a new game overrides everything.
   always_comb begin
      fsm_d      = fsm_q;
      estado_d   = estado_q;
      revelada_d = revelada_q;
      bandera_d  = bandera_q;
      cuenta_d   = cuenta_q;
      cel_d      = cel_q;
      k_d        = k_q;
      pila_push  = 1'b0;
      pila_pop   = 1'b0;
      pila_clr   = 1'b0;
      pila_din   = cel_q;

      if (iniciar_i) begin
         fsm_d      = IDLE;
         estado_d   = JUGANDO;
         revelada_d = '0;
         bandera_d  = '0;
         cuenta_d   = '0;
         pila_clr   = 1'b1;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (estado_q == JUGANDO) begin
                  if (btn_revelar_i) begin
                     cel_d = cursor_idx;
                     fsm_d = CHECK;
                  end else if (btn_bandera_i && !revelada_q[cursor_idx]) begin
                     bandera_d[cursor_idx] = ~bandera_q[cursor_idx];
                  end
               end
            end
            CHECK: begin
               if (bandera_q[cel_q] || revelada_q[cel_q]) begin
                  fsm_d = IDLE;
               end else if (minas_i[cel_q]) begin
                  revelada_d = revelada_q | minas_i;
                  estado_d   = PERDIDO;
                  fsm_d      = FIN;
               end else begin
                  revelada_d[cel_q] = 1'b1;
                  cuenta_d          = cuenta_q + 1'b1;
                  if (es_cero[cel_q]) begin
                     pila_push = 1'b1;
                     fsm_d     = POP;
                  end else begin
                     fsm_d     = VERIF;
                  end
               end
            end
            POP: begin
               if (pila_vacia) begin
                  fsm_d = VERIF;
               end else begin
                  pila_pop = 1'b1;
                  cel_d    = pila_dout;
                  k_d      = 3'd0;
                  fsm_d    = VECINO;
               end
            end
            VECINO: begin
               pila_din = vec_idx;
               if (vec_en_rango && !revelada_q[vec_idx] && !bandera_q[vec_idx]) begin
                  revelada_d[vec_idx] = 1'b1;
                  cuenta_d            = cuenta_q + 1'b1;
                  pila_push           = es_cero[vec_idx];
               end
               if (k_q == 3'd7) begin
                  fsm_d = POP;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end
            VERIF: begin
               if (&(revelada_q | minas_i)) begin
                  estado_d = GANADO;
                  fsm_d    = FIN;
               end else begin
                  fsm_d    = IDLE;
               end
            end
            FIN: begin
               fsm_d = FIN;
            end
            default: begin
               fsm_d = IDLE;
            end
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsm_q      <= IDLE;
         estado_q   <= ESPERA;
         revelada_q <= '0;
         bandera_q  <= '0;
         cuenta_q   <= '0;
         cel_q      <= '0;
         k_q        <= '0;
      end else begin
         fsm_q      <= fsm_d;
         estado_q   <= estado_d;
         revelada_q <= revelada_d;
         bandera_q  <= bandera_d;
         cuenta_q   <= cuenta_d;
         cel_q      <= cel_d;
         k_q        <= k_d;
      end
   end

   // Busy whenever a reveal is being processed.
   always_comb begin
      ocupado_o = (fsm_q == CHECK) || (fsm_q == POP) ||
                  (fsm_q == VECINO) || (fsm_q == VERIF);
   end

   assign revelada_o         = revelada_q;
   assign bandera_o          = bandera_q;
   assign estado_o           = estado_q;
   assign celdas_reveladas_o = cuenta_q;

endmodule

// File: tb/tb_revelar_celdas.sv
// Bench for revelar_celdas: directed game scenarios plus random games,
// checked against a queue-based flood-fill model of the game rules.
module tb_revelar_celdas;

   logic         clk = 1'b0;
   logic         rst;
   logic         iniciar, btn_revelar, btn_bandera;
   logic [2:0]   cursor_fila, cursor_col;
   logic [63:0]  minas;
   logic [191:0] conteos;
   logic [63:0]  revelada, bandera;
   logic [1:0]   estado;
   logic         ocupado;
   logic [6:0]   celdas_reveladas;

   always #5 clk = ~clk;

   revelar_celdas dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .iniciar_i          (iniciar),
      .btn_revelar_i      (btn_revelar),
      .btn_bandera_i      (btn_bandera),
      .cursor_fila_i      (cursor_fila),
      .cursor_col_i       (cursor_col),
      .minas_i            (minas),
      .conteos_i          (conteos),
      .revelada_o         (revelada),
      .bandera_o          (bandera),
      .estado_o           (estado),
      .ocupado_o          (ocupado),
      .celdas_reveladas_o (celdas_reveladas)
   );

   int checks_total = 0;
   int checks_ok    = 0;

   // Reference game state.
   logic [63:0] m_rev, m_flag;
   int          m_cnt;
   int          m_est;
   int          m_cont [64];

   task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
      checks_total++;
      if (obs === esp) checks_ok++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load a mine map and derive the adjacency counts (saturated at 7).
   task automatic cargar_mapa(input logic [63:0] mp);
      int n, rr, cc;
      minas = mp;
      for (int i = 0; i < 64; i++) begin
         n = 0;
         for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
               rr = i / 8 + dr;
               cc = i % 8 + dc;
               if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                  if (mp[rr*8+cc]) n++;
            end
         end
         if (n > 7) n = 7;
         m_cont[i] = n;
         conteos[i*3 +: 3] = 3'(n);
      end
   endtask

   // Reveal rule: flood by breadth-first worklist over zero-count cells.
   task automatic modelo_revelar(input int i, output int busy);
      int q[$];
      int pushed, c, rr, cc, j;
      busy = 1;
      if (m_flag[i] || m_rev[i]) return;
      if (minas[i]) begin
         m_rev = m_rev | minas;
         m_est = 2;
         return;
      end
      m_rev[i] = 1'b1;
      m_cnt++;
      if (m_cont[i] != 0) begin
         busy = 2;
      end else begin
         q.push_back(i);
         pushed = 1;
         while (q.size() > 0) begin
            c = q.pop_front();
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = c / 8 + dr;
                  cc = c % 8 + dc;
                  if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                     j = rr * 8 + cc;
                     if (!m_rev[j] && !m_flag[j]) begin
                        m_rev[j] = 1'b1;
                        m_cnt++;
                        if (m_cont[j] == 0) begin
                           q.push_back(j);
                           pushed++;
                        end
                     end
                  end
               end
            end
         end
         busy = 3 + 9 * pushed;
      end
      if (&(m_rev | minas)) m_est = 3;
   endtask

   task automatic comparar_estado(input string pre);
      comprobar({pre, "_revelada"}, revelada, m_rev);
      comprobar({pre, "_bandera"}, bandera, m_flag);
      comprobar({pre, "_estado"}, 64'(estado), 64'(m_est));
      comprobar({pre, "_cuenta"}, 64'(celdas_reveladas), 64'(m_cnt));
   endtask

   task automatic nueva_partida();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      m_rev  = '0;
      m_flag = '0;
      m_cnt  = 0;
      m_est  = 1;
      $display("iniciar: estado=%0d ocupado=%0d", estado, ocupado);
      comprobar("iniciar_ocupado", 64'(ocupado), 64'd0);
      comparar_estado("iniciar");
   endtask

   // One player action: drive buttons for one cycle, then time the busy window.
   task automatic accion(input bit rev, input bit flg, input int f, input int c, output int ciclos);
      int i, esp_busy;
      i = f * 8 + c;
      esp_busy = 0;
      if (m_est == 1) begin
         if (rev) modelo_revelar(i, esp_busy);
         else if (flg && !m_rev[i]) m_flag[i] = ~m_flag[i];
      end
      cursor_fila = 3'(f);
      cursor_col  = 3'(c);
      btn_revelar = rev;
      btn_bandera = flg;
      tick();
      btn_revelar = 1'b0;
      btn_bandera = 1'b0;
      ciclos = 0;
      while (ocupado && ciclos < 1000) begin
         ciclos++;
         tick();
      end
      $display("accion rev=%0d flag=%0d celda=(%0d,%0d) ciclos=%0d estado=%0d cuenta=%0d",
               rev, flg, f, c, ciclos, estado, celdas_reveladas);
      comprobar("ciclos_ocupado", 64'(ciclos), 64'(esp_busy));
      comparar_estado("accion");
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int ciclos, nm, sel;
      logic [63:0] mp;

      rst = 1'b1;
      iniciar = 1'b0;
      btn_revelar = 1'b0;
      btn_bandera = 1'b0;
      cursor_fila = '0;
      cursor_col  = '0;
      m_rev = '0;
      m_flag = '0;
      m_cnt = 0;
      m_est = 0;
      cargar_mapa(64'd1 << 19);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      $display("reset: estado=%0d ocupado=%0d", estado, ocupado);
      comprobar("reset_ocupado", 64'(ocupado), 64'd0);
      comparar_estado("reset");

      // Buttons before a game has started are ignored.
      accion(1, 0, 2, 3, ciclos);
      accion(0, 1, 4, 4, ciclos);

      // Mine hit at (2,3): all mines shown, then the game is frozen.
      nueva_partida();
      accion(1, 0, 2, 3, ciclos);
      comprobar("perdido_mascara", revelada, minas);
      accion(1, 0, 0, 0, ciclos);

      // Single non-zero reveal next to a mine at (1,1).
      cargar_mapa(64'd1 << 9);
      nueva_partida();
      accion(1, 0, 0, 0, ciclos);
      comprobar("simple_ciclos", 64'(ciclos), 64'd2);

      // Empty board: full flood of 64 cells.
      cargar_mapa(64'd0);
      nueva_partida();
      accion(1, 0, 3, 3, ciclos);
      comprobar("flood_579", 64'(ciclos), 64'd579);
      comprobar("flood_ganado", 64'(estado), 64'd3);

      // Flag blocks a reveal until toggled off.
      cargar_mapa(64'd1 << 45);
      nueva_partida();
      accion(0, 1, 4, 4, ciclos);
      accion(1, 0, 4, 4, ciclos);
      accion(0, 1, 4, 4, ciclos);
      accion(1, 0, 4, 4, ciclos);
      comprobar("bit36", 64'(revelada[36]), 64'd1);

      // Single mine in the corner: flood wins the game.
      cargar_mapa(64'd1 << 63);
      nueva_partida();
      accion(1, 0, 0, 0, ciclos);
      comprobar("esquina_mascara", revelada, ~(64'd1 << 63));

      // Same board, new game aborted mid-flood.
      nueva_partida();
      accion(0, 1, 2, 5, ciclos);
      btn_revelar = 1'b1;
      cursor_fila = 3'd0;
      cursor_col  = 3'd0;
      tick();
      btn_revelar = 1'b0;
      repeat (40) tick();
      comprobar("medio_flood_ocupado", 64'(ocupado), 64'd1);
      nueva_partida();
      accion(1, 0, 0, 0, ciclos);

      // Random games.
      for (int g = 0; g < 10; g++) begin
         mp = '0;
         nm = $urandom_range(1, 12);
         for (int m = 0; m < nm; m++) mp[$urandom_range(0, 63)] = 1'b1;
         cargar_mapa(mp);
         nueva_partida();
         for (int a = 0; a < 25; a++) begin
            sel = $urandom_range(0, 9);
            accion(sel <= 5 || sel == 9, sel >= 6, $urandom_range(0, 7), $urandom_range(0, 7), ciclos);
         end
      end

      $display("%0d/%0d checks passed", checks_ok, checks_total);
      $finish;
   end

endmodule
